// File: rtl/dpa_rx_prbs_checker_if.sv
// Receive-side lane bus of the PRBS7 training checker.
// The master side drives data and control; the slave side (the checker) returns lock and error status.
interface dpa_rx_prbs_checker_if #(
  parameter int LANES = 5,
  parameter int ERR_W = 16
);
  logic                   enable;
  logic                   rx_valid;
  logic [LANES-1:0]       rx_d_rise;
  logic [LANES-1:0]       rx_d_fall;
  logic                   clear_counters;
  logic [LANES-1:0]       lane_lock;
  logic                   all_lock;
  logic [LANES-1:0]       err_pulse;
  logic [LANES*ERR_W-1:0] err_cnt;

  modport master (
    output enable, rx_valid, rx_d_rise, rx_d_fall, clear_counters,
    input  lane_lock, all_lock, err_pulse, err_cnt
  );

  modport slave (
    input  enable, rx_valid, rx_d_rise, rx_d_fall, clear_counters,
    output lane_lock, all_lock, err_pulse, err_cnt
  );
endinterface

// File: rtl/dpa_rx_prbs_checker.sv
// Per-lane self-synchronising PRBS7 (x^7+x^6+1) checker with lock/unlock hysteresis,
// plus the top that replicates it across the deskewed RGMII lanes.
module dpa_rx_prbs_lane #(
  parameter int LOCK_CNT   = 64,
  parameter int WIN        = 256,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic             i_rise,
  input  logic             i_fall,
  input  logic             i_clr,
  output logic             o_lock,
  output logic             o_err,
  output logic [ERR_W-1:0] o_cnt
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {IDLE, FILL, HUNT, LOCKED} st_t;

  st_t             r_st;
  logic [6:0]      r_h;
  logic [1:0]      r_fill;
  logic [RW-1:0]   r_run;
  logic [WW-1:0]   r_win;
  logic [EW-1:0]   r_werr;
  logic [ERR_W-1:0] r_cnt;
  logic            r_lock;
  logic            r_err;

  logic            w_mis;
  logic            w_cnt_inc;

  // An all-zero history would predict zeros forever; treat it as a stuck lane.
  assign w_mis     = (i_rise != (r_h[6] ^ r_h[5])) | (i_fall != (r_h[5] ^ r_h[4])) | (r_h == 7'd0);
  assign w_cnt_inc = i_en & i_vld & (r_st == LOCKED) & w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= IDLE;
      r_h    <= '0;
      r_fill <= '0;
      r_run  <= '0;
      r_win  <= '0;
      r_werr <= '0;
      r_lock <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (!i_en) begin
        r_st   <= IDLE;
        r_h    <= '0;
        r_fill <= '0;
        r_run  <= '0;
        r_win  <= '0;
        r_werr <= '0;
        r_lock <= 1'b0;
      end else if (i_vld) begin
        r_h <= {r_h[4:0], i_rise, i_fall};
        case (r_st)
          // The enabling valid cycle is the first of the four history loads.
          IDLE: begin
            r_st   <= FILL;
            r_fill <= 2'd1;
          end
          FILL: begin
            r_fill <= r_fill + 2'd1;
            if (r_fill == 2'd3) begin
              r_st  <= HUNT;
              r_run <= '0;
            end
          end
          HUNT: begin
            if (w_mis) begin
              r_run <= '0;
            end else if (r_run == RW'(LOCK_CNT - 1)) begin
              r_st   <= LOCKED;
              r_lock <= 1'b1;
              r_run  <= '0;
              r_win  <= '0;
              r_werr <= '0;
            end else begin
              r_run <= r_run + 1'b1;
            end
          end
          LOCKED: begin
            r_err <= w_mis;
            r_win <= r_win + 1'b1;
            if (w_mis && (r_werr == EW'(UNLOCK_ERR - 1))) begin
              r_st   <= HUNT;
              r_lock <= 1'b0;
              r_run  <= '0;
            end else if (r_win == '1) begin
              r_werr <= '0;
            end else if (w_mis) begin
              r_werr <= r_werr + 1'b1;
            end
          end
          default: r_st <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (w_cnt_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign o_lock = r_lock;
  assign o_err  = r_err;
  assign o_cnt  = r_cnt;
endmodule

module dpa_rx_prbs_checker #(
  parameter int LANES      = 5,
  parameter int LOCK_CNT   = 64,
  parameter int WIN        = 256,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  dpa_rx_prbs_checker_if.slave bus
);
  logic [LANES-1:0]            w_lock;
  logic [LANES-1:0]            w_err;
  logic [LANES-1:0][ERR_W-1:0] w_cnt;
  logic                        r_all;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dpa_rx_prbs_lane #(
      .LOCK_CNT   (LOCK_CNT),
      .WIN        (WIN),
      .UNLOCK_ERR (UNLOCK_ERR),
      .ERR_W      (ERR_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (bus.enable),
      .i_vld  (bus.rx_valid),
      .i_rise (bus.rx_d_rise[i]),
      .i_fall (bus.rx_d_fall[i]),
      .i_clr  (bus.clear_counters),
      .o_lock (w_lock[i]),
      .o_err  (w_err[i]),
      .o_cnt  (w_cnt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_all <= 1'b0;
    else        r_all <= &w_lock;
  end

  assign bus.lane_lock = w_lock;
  assign bus.err_pulse = w_err;
  assign bus.all_lock  = r_all;
  assign bus.err_cnt   = w_cnt;
endmodule
